// File: rtl/if_id_stage.sv
// if_id_stage: fetch-to-decode pipeline register with field split; IF_ID_IMM_EN adds the immediate generator
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_funct3,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [6:0]  id_funct7,
    output logic [31:0] id_imm,
    output logic        id_illegal
);
    logic [31:0] pc_d, pc_q, instr_d, instr_q;
    logic        valid_d, valid_q;
    logic        supported;

    // flush outranks stall so a redirect is never lost behind a stall
    always_comb begin
        pc_d    = (flush || !stall) ? if_pc : pc_q;
        instr_d = flush ? NOP_INSTR : stall ? instr_q : if_instr;
        valid_d = flush ? 1'b0 : stall ? valid_q : if_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign id_pc     = pc_q;
    assign id_instr  = instr_q;
    assign id_valid  = valid_q;
    assign id_opcode = instr_q[6:0];
    assign id_rd     = instr_q[11:7];
    assign id_funct3 = instr_q[14:12];
    assign id_rs1    = instr_q[19:15];
    assign id_rs2    = instr_q[24:20];
    assign id_funct7 = instr_q[31:25];

    always_comb begin
        supported = id_opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    end

    assign id_illegal = valid_q && (!supported || instr_q[1:0] != 2'b11);

`ifdef IF_ID_IMM_EN
    always_comb begin
        id_imm = 32'h0;
        case (id_opcode)
            7'b0010011, 7'b0000011, 7'b1100111: id_imm = {{20{instr_q[31]}}, instr_q[31:20]};
            7'b0100011: id_imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            7'b1100011: id_imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
            7'b1101111: id_imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
            7'b0110111, 7'b0010111: id_imm = {instr_q[31:12], 12'b0};
            default: id_imm = 32'h0;
        endcase
    end
`else
    assign id_imm = 32'h0;
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: randomized bench for if_id_stage against an arithmetic reference model
module tb_if_id_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_pc = '0, if_instr = '0;
    logic        if_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] id_pc, id_instr, id_imm;
    logic        id_valid, id_illegal;
    logic [6:0]  id_opcode, id_funct7;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [2:0]  id_funct3;
    int          n_pass = 0, n_total = 0;
    logic [31:0] m_pc, m_instr;
    logic        m_valid;
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    if_id_stage dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
        .stall(stall), .flush(flush), .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_rd(id_rd), .id_funct3(id_funct3), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_funct7(id_funct7), .id_imm(id_imm), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic signed [31:0] si;
        logic [31:0] a20, a25, a31, op;
        si  = i;
        a20 = si >>> 20;
        a25 = si >>> 25;
        a31 = si >>> 31;
        op  = i & 32'h7F;
        if (op == 32'h13 || op == 32'h03 || op == 32'h67) return a20;
        if (op == 32'h23) return (a25 << 5) | ((i >> 7) & 32'h1F);
        if (op == 32'h63) return (a31 << 12) | (((i >> 7) & 1) << 11) | (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1);
        if (op == 32'h6F) return (a31 << 20) | (i & 32'h000F_F000) | (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1);
        if (op == 32'h37 || op == 32'h17) return i & 32'hFFFF_F000;
        return 32'h0;
    endfunction

    function automatic logic ref_illegal(input logic v, input logic [31:0] i);
        logic ok;
        ok = 1'b0;
        foreach (ops[k]) if ((i & 32'h7F) == 32'(ops[k])) ok = 1'b1;
        return v && !ok;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, id_pc, m_pc);
        chk({tag, ".instr"}, id_instr, m_instr);
        chk({tag, ".valid"}, 32'(id_valid), 32'(m_valid));
        chk({tag, ".opcode"}, 32'(id_opcode), m_instr & 32'h7F);
        chk({tag, ".rd"}, 32'(id_rd), (m_instr >> 7) & 32'h1F);
        chk({tag, ".funct3"}, 32'(id_funct3), (m_instr >> 12) & 32'h7);
        chk({tag, ".rs1"}, 32'(id_rs1), (m_instr >> 15) & 32'h1F);
        chk({tag, ".rs2"}, 32'(id_rs2), (m_instr >> 20) & 32'h1F);
        chk({tag, ".funct7"}, 32'(id_funct7), m_instr >> 25);
`ifdef IF_ID_IMM_EN
        chk({tag, ".imm"}, id_imm, ref_imm(m_instr));
`else
        chk({tag, ".imm"}, id_imm, 32'h0);
`endif
        chk({tag, ".illegal"}, 32'(id_illegal), 32'(ref_illegal(m_valid, m_instr)));
    endtask

    task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                        input logic v, input logic st, input logic fl);
        if_pc = pc; if_instr = ins; if_valid = v; stall = st; flush = fl;
        @(posedge clk);
        if (fl) begin
            m_pc = pc; m_instr = NOP; m_valid = 1'b0;
        end else if (!st) begin
            m_pc = pc; m_instr = ins; m_valid = v;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic rand_step();
        logic [31:0] r, ins;
        r = $urandom();
        ins = ($urandom_range(0, 7) == 0) ? r : ((r & ~32'h7F) | 32'(ops[$urandom_range(0, 8)]));
        step("rand", $urandom() & ~32'h3, ins, 1'($urandom_range(0, 1)),
             $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    endtask

    initial begin
        m_pc = '0; m_instr = NOP; m_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_all("reset_async");
        @(negedge clk) rst = 1'b0;
        step("s0", 32'h0, 32'h0050_0093, 1, 0, 0);
        chk("addi.rd", 32'(id_rd), 32'h1);
`ifdef IF_ID_IMM_EN
        chk("addi.imm", id_imm, 32'h5);
`endif
        step("s4", 32'h4, 32'h00A0_0113, 1, 0, 0);
        step("s8", 32'h8, 32'h0020_81B3, 1, 0, 0);
        step("pre_stall", 32'hC, 32'h0050_0093, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("stall", 32'h10 + 32'(i), 32'hDEAD_BEEF, 1, 1, 0);
        step("release", 32'h10, 32'h0000_0513, 1, 0, 0);
        step("flush_stall", 32'h40, 32'h0050_0093, 1, 1, 1);
        step("after_flush", 32'h44, 32'h00A0_0113, 1, 0, 0);
        step("beq", 32'h48, 32'hFE00_0EE3, 1, 0, 0);
`ifdef IF_ID_IMM_EN
        chk("beq.imm", id_imm, 32'hFFFF_FFFC);
`endif
        step("all_ones", 32'h4C, 32'hFFFF_FFFF, 1, 0, 0);
        chk("all_ones.illegal", 32'(id_illegal), 32'h1);
        step("invalid_load", 32'h50, 32'hFFFF_FFFF, 0, 0, 0);
        for (int i = 0; i < 300; i++) rand_step();
        step("pre_rst", 32'h100, 32'h0050_0093, 1, 0, 0);
        #2 rst = 1'b1;
        m_pc = '0; m_instr = NOP; m_valid = 1'b0;
        #1 check_all("reset_mid");
        @(negedge clk) check_all("reset_held");
        rst = 1'b0;
        for (int i = 0; i < 50; i++) rand_step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-to-decode pipeline register and field decoder for the RISC-V core. Captures the `pc`/`instr` pair produced by the fetch stage (program counter plus instruction memory) on each clock. Supports stall and flush, and presents the registered instruction to the decode/execute logic with its fields split out. When `IF_ID_IMM_EN` is defined, it also presents the sign-extended immediate. Sits directly downstream of fetch and upstream of the register file and ALU control.

## Interface

Parameters:
- `NOP_INSTR`, default `32'h0000_0013`: instruction loaded on reset and on flush (`addi x0,x0,0`).
- `RESET_PC`, default `32'h0000_0000`: `id_pc` value after reset.

Ports:
- `clk` input 1: the only clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `if_pc` input 32: PC from the fetch stage.
- `if_instr` input 32: instruction word read at `if_pc`.
- `if_valid` input 1: `if_pc`/`if_instr` hold a real instruction.
- `stall` input 1: hold the current contents; the fetch stage must also hold.
- `flush` input 1: discard the contents; load a bubble.
- `id_pc` output 32: registered PC.
- `id_instr` output 32: registered instruction.
- `id_valid` output 1: registered valid flag.
- `id_opcode` output 7: `id_instr[6:0]`.
- `id_rd` output 5: `id_instr[11:7]`.
- `id_funct3` output 3: `id_instr[14:12]`.
- `id_rs1` output 5: `id_instr[19:15]`.
- `id_rs2` output 5: `id_instr[24:20]`.
- `id_funct7` output 7: `id_instr[31:25]`.
- `id_imm` output 32: sign-extended immediate (see Configuration).
- `id_illegal` output 1: `id_valid` is high and the opcode is unsupported.

## Operation

- State is three registers: `id_pc`, `id_instr` and `id_valid`. Everything else is combinational from `id_instr` and `id_valid`.
- Update priority at each rising edge of `clk`:
  1. `flush`: `id_valid`←0, `id_instr`←`NOP_INSTR`, `id_pc`←`if_pc`.
  2. `stall`: all three registers hold.
  3. Otherwise: `id_pc`←`if_pc`, `id_instr`←`if_instr`, `id_valid`←`if_valid`.
- `flush` and `stall` asserted together: flush wins. A branch redirect must not be lost behind a stall.
- Loading with `if_valid`=0: `id_instr` still takes `if_instr` and `id_valid` becomes 0. Downstream logic ignores the contents.
- Supported opcodes: `0110011` (R), `0010011` (I-ALU), `0000011` (load), `0100011` (store), `1100011` (branch), `1101111` (JAL), `1100111` (JALR), `0110111` (LUI), `0010111` (AUIPC).
- `id_illegal` = `id_valid` AND (opcode not in the supported list OR `id_instr[1:0]`≠`2'b11`).
- Field outputs are raw bit slices, driven even when `id_valid`=0.

## Timing

- Reset (asynchronous, immediate on `rst` high, independent of `clk`): `id_pc`=`RESET_PC`, `id_instr`=`NOP_INSTR`, `id_valid`=0. Consequently `id_illegal`=0, `id_opcode`=`7'h13`, `id_rd`/`id_rs1`/`id_rs2`/`id_funct3`/`id_funct7`=0, `id_imm`=0.
- Reset asserted mid-stream discards the held instruction with no partial update. The first capture happens at the first rising edge after `rst` falls.
- Latency: 1 cycle from `if_*` to `id_*`. Decode outputs are valid in the same cycle as `id_instr`, with no further register.
- Stall lasting N cycles: the `id_*` outputs are constant for N cycles. The next instruction loads on the first edge with `stall`=0.
- Flush takes effect on one edge. The cycle after it, `id_valid`=0, and the next edge without flush/stall loads normally.

## Configuration

- `IF_ID_IMM_EN` defined: `id_imm` is generated by opcode type, all formats sign-extended from `instr[31]`:
  - I (`0010011`, `0000011`, `1100111`): `{{20{i[31]}},i[31:20]}`.
  - S: `{{20{i[31]}},i[31:25],i[11:7]}`.
  - B: `{{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}`.
  - J: `{{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}`.
  - U (`0110111`, `0010111`): `{i[31:12],12'b0}`.
  - R-type and unsupported opcodes: 0.
- `IF_ID_IMM_EN` not defined: `id_imm` is tied to `32'h0`. No immediate logic is synthesised; all other behaviour is unchanged.

## Test plan

- Reset with `rst`=1 asserted asynchronously between clock edges -> outputs update immediately: `id_valid`=0, `id_instr`=`32'h00000013`, `id_pc`=0, `id_illegal`=0.
- Stream `if_pc`=0,4,8 with `addi x1,x0,5` (`32'h00500093`) etc. and `if_valid`=1 -> each word appears one cycle later. For `32'h00500093`: `id_rd`=1, `id_rs1`=0, and `id_imm`=5 (`IF_ID_IMM_EN` defined) or 0 (not defined).
- Hold `stall`=1 for 3 cycles with `id_instr`=`32'h00500093` -> all `id_*` outputs constant. The next `if_instr` is captured on the first edge after release.
- `flush`=1 together with `stall`=1 -> next cycle `id_valid`=0, `id_instr`=`32'h00000013`.
- With `IF_ID_IMM_EN` defined, `beq x0,x0,-4` (`32'hFE000EE3`) -> `id_imm`=`32'hFFFFFFFC`. With `32'hFFFFFFFF` and `id_valid`=1 -> `id_illegal`=1.
